detect_event_logger: RTL and testbench

Downstream consumer of the 1011 sequence detector's one-bit Mealy output.
- Timestamps every asserted detector cycle with a free-running cycle counter.
- Buffers timestamps in a small FIFO that software/bench reads through a valid/ready handshake.
- Keeps sticky hit and drop statistics, so detector activity is never lost silently.

---
 rtl/detect_log_pkg.sv | 13 +
 rtl/event_fifo.sv | 53 +++++
 rtl/detect_event_logger.sv | 91 +++++++++
 tb/tb_detect_event_logger.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_log_pkg.sv
// Shared defaults and the saturating-counter helper for the detector event logger.
package detect_log_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   // Callers pass their counter's all-ones value as max, so one helper serves any width up to 32.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Small circular FIFO for logged events: a push is visible one cycle later, with no fall-through.
// A pop in the same edge frees a slot for a push even when full; flush empties the FIFO and overrides both.
module event_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   // The extra wrap bit distinguishes full from empty when the addresses match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps 1011-detector hits into a FIFO read with rd_valid/rd_ready, one cycle push-to-visible; full drops count.
// HIT_GAP_EN stores cycles since the previous hit instead of the absolute timestamp.
module detect_event_logger
   import detect_log_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hit,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [TS_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         hit_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] entry;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            drop;

   // clr wins over any hit or pop on the same edge.
   assign push = hit & ~clr;
   assign pop  = rd_ready & ~clr;
   assign drop = push & fifo_full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts <= '0;
      else     ts <= ts + TS_W'(1);
   end

`ifdef HIT_GAP_EN
   logic [TS_W-1:0] gap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              gap <= '0;
      else if (clr)         gap <= '0;
      else if (hit)         gap <= TS_W'(1);
      else if (gap != '1)   gap <= gap + TS_W'(1);
   end

   assign entry = gap;
`else
   assign entry = ts;
`endif

   event_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push),
      .pop   (pop),
      .din   (entry),
      .dout  (rd_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (level)
   );

   assign rd_valid = ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         hit_cnt  <= '0;
         drop_cnt <= '0;
      end else if (clr) begin
         overflow <= 1'b0;
         hit_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (push) hit_cnt <= CNT_W'(sat_inc(32'(hit_cnt), 32'(CNT_MAX)));
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), 32'(CNT_MAX)));
         end
      end
   end

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: directed scenarios plus random traffic against a queue-based model.
module tb_detect_event_logger;

   localparam int TS_W   = 16;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 8;
   localparam int TS_MAX = (1 << TS_W) - 1;
   localparam int C_MAX  = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   hit = 1'b0;
   logic                   clr = 1'b0;
   logic                   rd_ready = 1'b0;
   logic                   rd_valid;
   logic [TS_W-1:0]        rd_data;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic [CNT_W-1:0]       hit_cnt;
   logic [CNT_W-1:0]       drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: cycle number since reset, reference cycle for gaps, queued entries, statistics.
   int mq[$];
   int m_cyc;
   int m_ref;
   int m_hit;
   int m_drop;
   int m_ovf;

   always #5 clk = ~clk;

   detect_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .hit      (hit),
      .clr      (clr),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .level    (level),
      .overflow (overflow),
      .hit_cnt  (hit_cnt),
      .drop_cnt (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int m_entry();
`ifdef HIT_GAP_EN
      int g;
      g = m_cyc - m_ref;
      return (g > TS_MAX) ? TS_MAX : g;
`else
      return m_cyc % (TS_MAX + 1);
`endif
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_cyc  = 0;
      m_ref  = 0;
      m_hit  = 0;
      m_drop = 0;
      m_ovf  = 0;
   endfunction

   function automatic void model_edge(input bit h, input bit r, input bit c);
      if (c) begin
         mq.delete();
         m_hit  = 0;
         m_drop = 0;
         m_ovf  = 0;
         m_ref  = m_cyc + 1;
      end else begin
         if (r && mq.size() > 0) void'(mq.pop_front());
         if (h) begin
            m_hit = (m_hit < C_MAX) ? m_hit + 1 : C_MAX;
            if (mq.size() < DEPTH) mq.push_back(m_entry());
            else begin
               m_drop = (m_drop < C_MAX) ? m_drop + 1 : C_MAX;
               m_ovf  = 1;
            end
            m_ref = m_cyc;
         end
      end
      m_cyc++;
   endfunction

   task automatic check_all();
      int head;
      head = 0;
      if (mq.size() > 0) head = mq[0];
      check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      check("rd_data",  32'(rd_data),  32'(head));
      check("level",    32'(level),    32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("hit_cnt",  32'(hit_cnt),  32'(m_hit));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
   endtask

   // Drives at a falling edge, updates the model on the rising edge, checks at the next falling edge.
   task automatic step(input bit h, input bit r, input bit c);
      hit = h;
      rd_ready = r;
      clr = c;
      @(posedge clk);
      model_edge(h, r, c);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < 1000 && m_cyc < target; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Asserts rst between clock edges and checks outputs clear before any edge arrives.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      hit = 1'b0;
      rd_ready = 1'b0;
      clr = 1'b0;
      #1;
      model_reset();
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data",  32'(rd_data),  32'd0);
      check("rst_level",    32'(level),    32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Two hits, then a one-cycle read.
      idle_until(3);
      step(1'b1, 1'b0, 1'b0);
      idle_until(6);
      step(1'b1, 1'b0, 1'b0);
      check("s1_level", 32'(level), 32'd2);
      check("s1_head", 32'(rd_data), 32'd3);
      step(1'b0, 1'b1, 1'b0);
      check("s1_level_pop", 32'(level), 32'd1);
`ifdef HIT_GAP_EN
      check("s1_head_pop", 32'(rd_data), 32'd3);
`else
      check("s1_head_pop", 32'(rd_data), 32'd6);
`endif

      // Overflow with six hits into four slots, then push+pop while full.
      do_reset();
      idle_until(10);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
      check("s2_level", 32'(level), 32'd4);
      check("s2_overflow", 32'(overflow), 32'd1);
      check("s2_drop_cnt", 32'(drop_cnt), 32'd2);
      check("s2_hit_cnt", 32'(hit_cnt), 32'd6);
`ifndef HIT_GAP_EN
      check("s2_head", 32'(rd_data), 32'd10);
`endif
      idle_until(20);
      step(1'b1, 1'b1, 1'b0);
      check("s3_level", 32'(level), 32'd4);
      check("s3_drop_cnt", 32'(drop_cnt), 32'd2);
`ifndef HIT_GAP_EN
      check("s3_head", 32'(rd_data), 32'd11);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("s3_newest", 32'(rd_data), 32'd20);
`endif
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);

      // clr with a simultaneous hit while three entries are held.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      check("s4_level_pre", 32'(level), 32'd3);
      step(1'b1, 1'b1, 1'b1);
      check("s4_level", 32'(level), 32'd0);
      check("s4_rd_valid", 32'(rd_valid), 32'd0);
      check("s4_hit_cnt", 32'(hit_cnt), 32'd0);
      check("s4_overflow", 32'(overflow), 32'd0);
      step(1'b1, 1'b0, 1'b0);
`ifdef HIT_GAP_EN
      check("s4_after_clr", 32'(rd_data), 32'd0);
`else
      check("s4_after_clr", 32'(rd_data), 32'd4);
`endif

      // Reset mid-stream with two entries queued; first edge afterwards samples zero.
      step(1'b1, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      check("s5_first_entry", 32'(rd_data), 32'd0);
      check("s5_level", 32'(level), 32'd1);

`ifdef HIT_GAP_EN
      do_reset();
      idle_until(5);
      step(1'b1, 1'b0, 1'b0);
      idle_until(9);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("gap_first", 32'(rd_data), 32'd5);
      step(1'b0, 1'b1, 1'b0);
      check("gap_second", 32'(rd_data), 32'd4);
      step(1'b0, 1'b1, 1'b0);
      check("gap_third", 32'(rd_data), 32'd1);
`endif

      // Counter saturation.
      do_reset();
      for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
      check("sat_hit_cnt", 32'(hit_cnt), 32'd255);
      check("sat_drop_cnt", 32'(drop_cnt), 32'd255);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 40) == 0));
      end
      for (int i = 0; i < 500; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
